// File: rtl/apd_gated_counter.sv
// apd_gated_counter
// Counts single-cycle APD pulses on channels A and B, plus their same-cycle
// coincidences, over back-to-back programmable gate windows. Each finished
// window is presented on a valid/ready output with saturation and overrun
// flags.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no window running; on enable, latch the window length and start
// COUNT | gate open; accumulate pulses until the last window cycle
module apd_gated_counter #(
    parameter int CNT_W = 32,
    parameter int WIN_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pulse_a,
    input  logic             pulse_b,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_cycles,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
    output logic [CNT_W-1:0] count_ab,
    output logic             saturated,
    output logic             overrun,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};

    state_t           r_state;
    logic             r_busy;
    logic [WIN_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_acc_a;
    logic [CNT_W-1:0] r_acc_b;
    logic [CNT_W-1:0] r_acc_ab;
    logic             r_sat_a;
    logic             r_sat_b;
    logic             r_sat_ab;

    logic [CNT_W-1:0] r_count_a;
    logic [CNT_W-1:0] r_count_b;
    logic [CNT_W-1:0] r_count_ab;
    logic             r_saturated;
    logic             r_overrun;
    logic             r_data_valid;

    logic [WIN_W-1:0] w_rem_start;
    logic [CNT_W-1:0] w_nxt_a;
    logic [CNT_W-1:0] w_nxt_b;
    logic [CNT_W-1:0] w_nxt_ab;
    logic             w_nxt_sat_a;
    logic             w_nxt_sat_b;
    logic             w_nxt_sat_ab;
    logic             w_coinc;
    logic             w_done;
    logic             w_accept;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v,
                                                    input logic inc);
        return (inc && (v != CNT_MAX)) ? (v + CNT_ONE) : v;
    endfunction

    // A zero-length window behaves as a one-cycle window.
    assign w_rem_start = (window_cycles == WIN_ZERO) ? WIN_ZERO
                                                     : (window_cycles - WIN_ONE);

    assign w_coinc      = pulse_a & pulse_b;
    assign w_nxt_a      = f_sat_inc(r_acc_a, pulse_a);
    assign w_nxt_b      = f_sat_inc(r_acc_b, pulse_b);
    assign w_nxt_ab     = f_sat_inc(r_acc_ab, w_coinc);
    assign w_nxt_sat_a  = r_sat_a  | (w_nxt_a  == CNT_MAX);
    assign w_nxt_sat_b  = r_sat_b  | (w_nxt_b  == CNT_MAX);
    assign w_nxt_sat_ab = r_sat_ab | (w_nxt_ab == CNT_MAX);

    // The last window cycle completes the window even if enable drops on it;
    // its pulses were already inside the gate.
    assign w_done   = (r_state == COUNT) && (r_remaining == WIN_ZERO);
    assign w_accept = r_data_valid & data_ready;

    // Window sequencing and pulse accumulation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_remaining <= WIN_ZERO;
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_acc_ab    <= '0;
            r_sat_a     <= 1'b0;
            r_sat_b     <= 1'b0;
            r_sat_ab    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_remaining <= w_rem_start;
                        r_state     <= COUNT;
                        r_busy      <= 1'b1;
                    end
                end
                COUNT: begin
                    if (w_done || !enable) begin
                        r_acc_a  <= '0;
                        r_acc_b  <= '0;
                        r_acc_ab <= '0;
                        r_sat_a  <= 1'b0;
                        r_sat_b  <= 1'b0;
                        r_sat_ab <= 1'b0;
                        if (enable) begin
                            r_remaining <= w_rem_start;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_acc_a     <= w_nxt_a;
                        r_acc_b     <= w_nxt_b;
                        r_acc_ab    <= w_nxt_ab;
                        r_sat_a     <= w_nxt_sat_a;
                        r_sat_b     <= w_nxt_sat_b;
                        r_sat_ab    <= w_nxt_sat_ab;
                        r_remaining <= r_remaining - WIN_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Result registers and valid/ready handshake with sticky overrun.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count_a    <= '0;
            r_count_b    <= '0;
            r_count_ab   <= '0;
            r_saturated  <= 1'b0;
            r_overrun    <= 1'b0;
            r_data_valid <= 1'b0;
        end else if (w_done) begin
            r_count_a    <= w_nxt_a;
            r_count_b    <= w_nxt_b;
            r_count_ab   <= w_nxt_ab;
            r_saturated  <= w_nxt_sat_a | w_nxt_sat_b | w_nxt_sat_ab;
            r_data_valid <= 1'b1;
            // Loss only if an unaccepted result is replaced; overrun is only
            // ever set while valid, so this also keeps it sticky.
            r_overrun    <= r_data_valid & ~data_ready;
        end else if (w_accept) begin
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end
    end

    assign count_a    = r_count_a;
    assign count_b    = r_count_b;
    assign count_ab   = r_count_ab;
    assign saturated  = r_saturated;
    assign overrun    = r_overrun;
    assign data_valid = r_data_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_apd_gated_counter.sv
// Directed bench for apd_gated_counter: a 32-bit instance for the main
// scenarios and a 4-bit instance for saturation.
module tb_apd_gated_counter;

    logic        clock;
    logic        reset_n;
    logic        pulse_a, pulse_b, enable, data_ready;
    logic [31:0] window_cycles;
    logic [31:0] count_a, count_b, count_ab;
    logic        saturated, overrun, data_valid, busy;

    logic        pa4, pb4, en4, rdy4;
    logic [31:0] win4;
    logic [3:0]  ca4, cb4, cab4;
    logic        sat4, ovr4, val4, busy4;

    int checks = 0;
    int errors = 0;

    apd_gated_counter #(.CNT_W(32), .WIN_W(32)) u_dut (
        .clock(clock), .reset_n(reset_n), .pulse_a(pulse_a), .pulse_b(pulse_b),
        .enable(enable), .window_cycles(window_cycles), .count_a(count_a),
        .count_b(count_b), .count_ab(count_ab), .saturated(saturated),
        .overrun(overrun), .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy)
    );

    apd_gated_counter #(.CNT_W(4), .WIN_W(32)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .pulse_a(pa4), .pulse_b(pb4),
        .enable(en4), .window_cycles(win4), .count_a(ca4),
        .count_b(cb4), .count_ab(cab4), .saturated(sat4),
        .overrun(ovr4), .data_valid(val4), .data_ready(rdy4),
        .busy(busy4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_gap();
        enable  = 1'b0;
        pulse_a = 1'b0;
        pulse_b = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset_n = 1'b0; pulse_a = 0; pulse_b = 0; enable = 0; data_ready = 1;
        window_cycles = 32'd10;
        pa4 = 0; pb4 = 0; en4 = 0; rdy4 = 1; win4 = 32'd20;
        step();
        step();
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_count_a", count_a, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        step();

        // 1: window 10, A on 2,5,8 ; B on 3,9
        window_cycles = 32'd10; enable = 1'b1;
        step();
        for (int i = 1; i <= 10; i++) begin
            pulse_a = (i == 2 || i == 5 || i == 8);
            pulse_b = (i == 3 || i == 9);
            step();
            if (i == 9) chk("t1_valid_early", {31'd0, data_valid}, 32'd0);
        end
        chk("t1_valid", {31'd0, data_valid}, 32'd1);
        chk("t1_count_a", count_a, 32'd3);
        chk("t1_count_b", count_b, 32'd2);
        chk("t1_count_ab", count_ab, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        idle_gap();
        chk("t1_valid_drop", {31'd0, data_valid}, 32'd0);

        // 2: coincidences on 1,4,7,10 (last cycle included)
        window_cycles = 32'd10; enable = 1'b1;
        step();
        for (int i = 1; i <= 10; i++) begin
            pulse_a = (i == 1 || i == 4 || i == 7 || i == 10);
            pulse_b = pulse_a;
            step();
        end
        chk("t2_count_a", count_a, 32'd4);
        chk("t2_count_b", count_b, 32'd4);
        chk("t2_count_ab", count_ab, 32'd4);
        chk("t2_sat", {31'd0, saturated}, 32'd0);
        idle_gap();

        // 3: ready low, two 3-cycle windows back to back
        data_ready = 1'b0; window_cycles = 32'd3; enable = 1'b1;
        step();
        for (int i = 1; i <= 6; i++) begin
            pulse_a = (i == 1 || i == 4 || i == 5);
            pulse_b = (i == 6);
            step();
            if (i == 3) begin
                chk("t3_w1_count_a", count_a, 32'd1);
                chk("t3_w1_overrun", {31'd0, overrun}, 32'd0);
            end
        end
        chk("t3_count_a", count_a, 32'd2);
        chk("t3_count_b", count_b, 32'd1);
        chk("t3_valid", {31'd0, data_valid}, 32'd1);
        chk("t3_overrun", {31'd0, overrun}, 32'd1);
        data_ready = 1'b1; enable = 1'b0; pulse_a = 0; pulse_b = 0;
        step();
        data_ready = 1'b0;
        chk("t3_valid_acc", {31'd0, data_valid}, 32'd0);
        chk("t3_overrun_acc", {31'd0, overrun}, 32'd0);
        step();
        data_ready = 1'b1;
        idle_gap();

        // 4: abort at cycle 50 of a 100-cycle window, then a fresh window
        window_cycles = 32'd100; enable = 1'b1;
        step();
        for (int i = 1; i <= 49; i++) begin
            pulse_a = i[0];
            step();
        end
        enable = 1'b0; pulse_a = 1'b0;
        step();
        chk("t4_busy_abort", {31'd0, busy}, 32'd0);
        chk("t4_valid_abort", {31'd0, data_valid}, 32'd0);
        chk("t4_hold_a", count_a, 32'd2);
        chk("t4_hold_b", count_b, 32'd1);
        step();
        step();
        chk("t4_valid_idle", {31'd0, data_valid}, 32'd0);
        enable = 1'b1;
        step();
        for (int i = 1; i <= 100; i++) begin
            pulse_a = (i == 10 || i == 20 || i == 30);
            pulse_b = (i == 99 || i == 100);
            step();
            if (i == 99) begin
                chk("t4_valid_early", {31'd0, data_valid}, 32'd0);
                chk("t4_busy_run", {31'd0, busy}, 32'd1);
            end
        end
        chk("t4_valid", {31'd0, data_valid}, 32'd1);
        chk("t4_count_a", count_a, 32'd3);
        chk("t4_count_b", count_b, 32'd2);
        idle_gap();

        // 5: 4-bit counters, pulse_a high for all 20 cycles
        win4 = 32'd20; en4 = 1'b1;
        step();
        for (int i = 1; i <= 20; i++) begin
            pa4 = 1'b1;
            step();
        end
        pa4 = 1'b0; en4 = 1'b0;
        chk("t5_count_a", {28'd0, ca4}, 32'd15);
        chk("t5_sat", {31'd0, sat4}, 32'd1);
        chk("t5_count_b", {28'd0, cb4}, 32'd0);

        // 6: zero-length window, pulse every cycle, then async reset
        window_cycles = 32'd0; enable = 1'b1; pulse_a = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t6_valid", {31'd0, data_valid}, 32'd1);
            chk("t6_count_a", count_a, 32'd1);
            chk("t6_overrun", {31'd0, overrun}, 32'd0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, data_valid}, 32'd0);
        chk("t6_rst_count_a", count_a, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        enable = 1'b0; pulse_a = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("t6_post_rst_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
